excp_irq_arb: RTL and testbench
===============================

Name: excp_irq_arb

Overview:
- Parametrised N-channel interrupt arbiter and WFI controller for the exu exception path; successor to the fixed three-source (ext/sft/tmr) irq logic.
- Latches level interrupts, applies per-channel enable and priority, and presents one registered trap request with cause and flush address to the exu commit stage.
- Tracks the in-service interrupt until mret, sequences WFI sleep/wake, and supports direct or vectored mtvec.

Parameters:
NUM_IRQ, 8, number of interrupt channels (2..32)
PRIO_W, 3, priority field width per channel; larger value = higher priority
XLEN, 32, CSR width
PC_SIZE, 32, flush address width
CAUSE_BASE, 16, mcause code of channel 0; channel k uses CAUSE_BASE+k

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
irq_i  in  NUM_IRQ  level interrupt lines, already synchronised
irq_en_i  in  NUM_IRQ  per-channel enable (mie bits)
irq_prio_i  in  NUM_IRQ*PRIO_W  channel priorities; channel k occupies bits [k*PRIO_W +: PRIO_W]
status_mie_r  in  1  global interrupt enable
dbg_mode  in  1  core is in debug mode
csr_mtvec_r  in  XLEN  trap vector; bits [1:0]==01 selects vectored mode
cmt_vld_i  in  1  commit stage can take a trap this cycle
mret_i  in  1  mret committed; completes the in-service interrupt
alu_wfi_i  in  1  WFI instruction committed
wfi_halt_ack  in  1  pipeline has halted for WFI
irq_req_o  out  1  registered interrupt request
irq_id_o  out  $clog2(NUM_IRQ)  winning channel index
irq_cause_o  out  XLEN  mcause value for the winning channel
irq_flush_addr_o  out  PC_SIZE  trap target address
irq_taken_o  out  1  single-cycle pulse: trap accepted
wfi_flag_r  out  1  a WFI is pending or active
core_wfi  out  1  core is asleep

Behaviour:
- All outputs reset to 0. In-service state clears on reset; the WFI FSM returns to RUN.
- Eligibility: eligible[k] = irq_i[k] & irq_en_i[k].
- Arbitration is combinational over eligible channels:
  - the highest irq_prio_i wins;
  - ties go to the lowest index.
- Request gating: irq_req_o is registered (1-cycle latency from irq_i) and asserts when all of the following hold:
  - a winner exists;
  - status_mie_r = 1;
  - dbg_mode = 0;
  - no interrupt is in service.
- irq_id_o and irq_cause_o are registered with irq_req_o.
- irq_cause_o = {1'b1, (XLEN-1)-bit value CAUSE_BASE+id}.
- Flush address:
  - direct mode: {mtvec[PC_SIZE-1:2], 2'b00};
  - vectored mode: that base + 4*(CAUSE_BASE+id), truncated to PC_SIZE (wraps).
- Handshake: taken = irq_req_o & cmt_vld_i.
  - irq_taken_o pulses for 1 cycle.
  - The registered id is latched as in-service and insvc_busy is set.
  - irq_req_o deasserts the next cycle.
- If the winner changes while cmt_vld_i = 0, the request updates to the new winner (no stickiness).
- If irq_i drops before acceptance, the request withdraws.
- mret_i clears insvc_busy. A new request can appear the cycle after mret.
- mret_i with insvc_busy = 0 is ignored.
- mret_i and taken in the same cycle: taken wins and busy stays set.
- WFI FSM:
  - RUN -> WAIT on alu_wfi_i & ~dbg_mode; alu_wfi_i in dbg_mode is a nop.
  - WAIT -> SLEEP on wfi_halt_ack.
  - WAIT or SLEEP -> RUN when any eligible[k] = 1. This wake condition ignores status_mie_r and insvc_busy.
  - wfi_flag_r = 1 in WAIT and SLEEP; core_wfi = 1 in SLEEP only.
  - Wake and halt_ack in the same cycle: wake wins and the FSM goes to RUN.
- Requests are gated off while wfi_flag_r = 1. After wake, irq_req_o may assert the following cycle if all request conditions hold.

Optional Feature:
- Macro EXCP_IRQ_NESTING_EN.
- Defined:
  - an in-service priority stack of depth 4 (id and priority) replaces insvc_busy;
  - a request is allowed when the stack is empty or the winner's priority is strictly greater than the top-of-stack priority;
  - taken pushes onto the stack; mret_i pops it;
  - a push when the stack is full is blocked, i.e. no request is raised.
- Undefined: single in-service flag as described above; no preemption.

Test Plan:
- NUM_IRQ=8: irq_i=0x24, all enabled, prio[2]=prio[5]=3, mie=1 -> 1 cycle later irq_req_o=1, irq_id_o=2, irq_cause_o=0x80000012.
- mtvec=0x00001001, winner id 5, cmt_vld_i=1 -> irq_flush_addr_o=0x00001054, irq_taken_o pulses once, irq_req_o=0 next cycle and stays 0 until mret_i.
- Request active, cmt_vld_i=0 for 3 cycles, higher-priority irq 7 rises -> irq_id_o switches to 7; irq 7 dropped before acceptance -> request withdraws, no irq_taken_o.
- alu_wfi_i, then wfi_halt_ack -> core_wfi=1; irq_i[1]=1 with mie=0 -> core_wfi=0 next cycle and irq_req_o stays 0; with mie=1 -> irq_req_o=1 the cycle after wake.
- dbg_mode=1 with eligible irq -> irq_req_o=0; alu_wfi_i in dbg_mode -> wfi_flag_r stays 0.
- Nesting build: irq 1 (prio 2) taken, then irq 4 (prio 5) -> taken with stack depth 2; irq 3 (prio 2) -> blocked; after two mret_i -> irq 3 requested.

Source files
------------

// File: rtl/excp_irq_arb_if.sv
// excp_irq_arb_if: trap request/accept handshake between the irq arbiter and the exu commit stage
interface excp_irq_arb_if #(
    parameter int NUM_IRQ = 8,
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32
);
    logic                       irq_req_o;
    logic [$clog2(NUM_IRQ)-1:0] irq_id_o;
    logic [XLEN-1:0]            irq_cause_o;
    logic [PC_SIZE-1:0]         irq_flush_addr_o;
    logic                       irq_taken_o;
    logic                       cmt_vld_i;
    logic                       mret_i;
    modport master (
        output irq_req_o, irq_id_o, irq_cause_o, irq_flush_addr_o, irq_taken_o,
        input  cmt_vld_i, mret_i
    );
    modport slave (
        input  irq_req_o, irq_id_o, irq_cause_o, irq_flush_addr_o, irq_taken_o,
        output cmt_vld_i, mret_i
    );
endinterface

// File: rtl/excp_irq_arb.sv
// excp_irq_arb: N-channel priority irq arbiter with in-service tracking and WFI sleep/wake sequencing
// Define EXCP_IRQ_NESTING_EN for a 4-deep in-service priority stack allowing preemption.
module excp_irq_arb #(
    parameter int NUM_IRQ    = 8,
    parameter int PRIO_W     = 3,
    parameter int XLEN       = 32,
    parameter int PC_SIZE    = 32,
    parameter int CAUSE_BASE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IRQ-1:0]        irq_i,
    input  logic [NUM_IRQ-1:0]        irq_en_i,
    input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio_i,
    input  logic                      status_mie_r,
    input  logic                      dbg_mode,
    input  logic [XLEN-1:0]           csr_mtvec_r,
    input  logic                      alu_wfi_i,
    input  logic                      wfi_halt_ack,
    output logic                      wfi_flag_r,
    output logic                      core_wfi,
    excp_irq_arb_if.master            bus
);
    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_SLEEP} wfi_st_e;

    wfi_st_e            st, st_nxt;
    logic [NUM_IRQ-1:0] eligible;
    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic [XLEN-2:0]    cause_code;
    logic [PC_SIZE-1:0] base, flush;
    logic               taken, insvc_ok, req_d;

    assign eligible = irq_i & irq_en_i;

    // Descending scan with >= lets the lowest index win priority ties
    always_comb begin
        win_vld = 1'b0;
        win_id = '0;
        win_prio = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (eligible[k] && (!win_vld || irq_prio_i[k*PRIO_W +: PRIO_W] >= win_prio)) begin
                win_vld = 1'b1;
                win_id = ID_W'(k);
                win_prio = irq_prio_i[k*PRIO_W +: PRIO_W];
            end
    end

    assign cause_code = (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(win_id);
    assign base       = {csr_mtvec_r[PC_SIZE-1:2], 2'b00};
    assign flush      = csr_mtvec_r[1:0] == 2'b01 ? base + (PC_SIZE'(cause_code) << 2) : base;
    assign taken      = bus.irq_req_o & bus.cmt_vld_i;
    assign bus.irq_taken_o = taken;

`ifdef EXCP_IRQ_NESTING_EN
    logic [2:0]        depth, depth_nxt;
    logic [PRIO_W-1:0] stk [4];
    logic [PRIO_W-1:0] req_prio, top_nxt;
    logic              push;
    assign push = taken && depth != 3'd4;
    // Gate on the post-edge stack so a take or mret this cycle is reflected immediately
    always_comb begin
        depth_nxt = push ? depth + 3'd1 : (bus.mret_i && !taken && depth != 3'd0) ? depth - 3'd1 : depth;
        top_nxt = push ? req_prio : stk[2'(depth_nxt - 3'd1)];
        insvc_ok = depth_nxt == 3'd0 || (depth_nxt != 3'd4 && win_prio > top_nxt);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            req_prio <= '0;
        end else begin
            depth <= depth_nxt;
            req_prio <= win_prio;
            if (push) stk[depth[1:0]] <= req_prio;
        end
    end
`else
    logic busy, busy_nxt;
    assign busy_nxt = taken | (busy & ~bus.mret_i);
    assign insvc_ok = ~busy_nxt;
    always_ff @(posedge clk) busy <= rst ? 1'b0 : busy_nxt;
`endif

    assign req_d = win_vld & status_mie_r & ~dbg_mode & ~wfi_flag_r & insvc_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.irq_req_o <= 1'b0;
            bus.irq_id_o <= '0;
            bus.irq_cause_o <= '0;
            bus.irq_flush_addr_o <= '0;
        end else begin
            bus.irq_req_o <= req_d;
            bus.irq_id_o <= req_d ? win_id : '0;
            bus.irq_cause_o <= req_d ? {1'b1, cause_code} : '0;
            bus.irq_flush_addr_o <= req_d ? flush : '0;
        end
    end

    always_ff @(posedge clk) st <= rst ? ST_RUN : st_nxt;

    // Wake ignores mie and in-service state, and beats a same-cycle halt ack
    always_comb begin
        st_nxt = st != ST_RUN && |eligible ? ST_RUN :
                 st == ST_RUN && alu_wfi_i && !dbg_mode ? ST_WAIT :
                 st == ST_WAIT && wfi_halt_ack ? ST_SLEEP : st;
        wfi_flag_r = st != ST_RUN;
        core_wfi = st == ST_SLEEP;
    end
endmodule

// File: tb/tb_excp_irq_arb.sv
// tb_excp_irq_arb: scoreboard bench for excp_irq_arb (NUM_IRQ=8, PRIO_W=3, XLEN=PC_SIZE=32)
module tb_excp_irq_arb;
    typedef struct {
        string       tag;
        bit          req;
        int          id;
        logic [31:0] cause;
        logic [31:0] flush;
        bit          wfi;
        bit          cwfi;
        int          tk;
    } exp_t;

    logic        clk, rst;
    logic [7:0]  irq, en;
    logic [23:0] prio;
    logic        mie, dbg, alu_wfi, halt;
    logic [31:0] mtvec;
    logic        wfi_flag, cwfi;
    exp_t        q[$];
    exp_t        e;
    int          n_chk, n_err, tk_cnt, exp_tk;

    excp_irq_arb_if #(.NUM_IRQ(8), .XLEN(32), .PC_SIZE(32)) bus ();

    excp_irq_arb dut (
        .clk(clk), .rst(rst), .irq_i(irq), .irq_en_i(en), .irq_prio_i(prio),
        .status_mie_r(mie), .dbg_mode(dbg), .csr_mtvec_r(mtvec), .alu_wfi_i(alu_wfi),
        .wfi_halt_ack(halt), .wfi_flag_r(wfi_flag), .core_wfi(cwfi), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input bit req, input int id, input logic [31:0] flush,
                        input bit wfi, input bit cw);
        exp_t x;
        x.tag = tag; x.req = req; x.id = id; x.cause = 32'h8000_0010 + 32'(id);
        x.flush = flush; x.wfi = wfi; x.cwfi = cw; x.tk = exp_tk;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic set_prio(input int ch, input int p);
        prio[ch*3 +: 3] = 3'(p);
    endtask

    always @(posedge clk) if (bus.irq_taken_o) tk_cnt++;

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.tag, "_req"}, 64'(bus.irq_req_o), 64'(e.req));
            chk({e.tag, "_wfi"}, 64'(wfi_flag), 64'(e.wfi));
            chk({e.tag, "_cwfi"}, 64'(cwfi), 64'(e.cwfi));
            chk({e.tag, "_taken"}, 64'(tk_cnt), 64'(e.tk));
            if (e.req) begin
                chk({e.tag, "_id"}, 64'(bus.irq_id_o), 64'(e.id));
                chk({e.tag, "_cause"}, 64'(bus.irq_cause_o), 64'(e.cause));
                chk({e.tag, "_flush"}, 64'(bus.irq_flush_addr_o), 64'(e.flush));
            end
        end
    end

    initial begin
        rst = 1; irq = 0; en = 0; prio = 0; mie = 0; dbg = 0; alu_wfi = 0; halt = 0;
        mtvec = 32'h1000; bus.cmt_vld_i = 0; bus.mret_i = 0;
        n_chk = 0; n_err = 0; tk_cnt = 0; exp_tk = 0;
        @(negedge clk);
        step("rst", 0, 0, 0, 0, 0);
        rst = 0; en = 8'hFF; mie = 1; set_prio(2, 3); set_prio(5, 3); irq = 8'h24;
        step("tie", 1, 2, 32'h1000, 0, 0);
        step("tie_hold", 1, 2, 32'h1000, 0, 0);
        mtvec = 32'h1001; set_prio(5, 4);
        step("vec", 1, 5, 32'h1054, 0, 0);
        bus.cmt_vld_i = 1; exp_tk = 1;
        step("take", 0, 0, 0, 0, 0);
        bus.cmt_vld_i = 0;
        repeat (3) step("insvc", 0, 0, 0, 0, 0);
        bus.mret_i = 1;
        step("mret", 1, 5, 32'h1054, 0, 0);
        bus.mret_i = 0;
        step("post_mret", 1, 5, 32'h1054, 0, 0);
        bus.mret_i = 1;
        step("mret_idle", 1, 5, 32'h1054, 0, 0);
        bus.cmt_vld_i = 1; exp_tk = 2;
        step("take_mret", 0, 0, 0, 0, 0);
        bus.cmt_vld_i = 0; bus.mret_i = 0;
        step("busy_kept", 0, 0, 0, 0, 0);
        bus.mret_i = 1;
        step("mret2", 1, 5, 32'h1054, 0, 0);
        bus.mret_i = 0;
        repeat (3) step("no_cmt", 1, 5, 32'h1054, 0, 0);
        irq = 8'hA4; set_prio(7, 7);
        step("switch", 1, 7, 32'h105C, 0, 0);
        irq = 8'h00;
        step("withdraw", 0, 0, 0, 0, 0);
        step("withdraw2", 0, 0, 0, 0, 0);
        alu_wfi = 1;
        step("wfi", 0, 0, 0, 1, 0);
        alu_wfi = 0; halt = 1;
        step("sleep", 0, 0, 0, 1, 1);
        halt = 0;
        step("sleep_hold", 0, 0, 0, 1, 1);
        mie = 0; irq = 8'h02;
        step("wake_nomie", 0, 0, 0, 0, 0);
        step("nomie_hold", 0, 0, 0, 0, 0);
        irq = 0; mie = 1; alu_wfi = 1;
        step("wfi2", 0, 0, 0, 1, 0);
        alu_wfi = 0; halt = 1;
        step("sleep2", 0, 0, 0, 1, 1);
        halt = 0; irq = 8'h02;
        step("wake2", 0, 0, 0, 0, 0);
        step("req_after_wake", 1, 1, 32'h1044, 0, 0);
        irq = 0; alu_wfi = 1;
        step("wfi3", 0, 0, 0, 1, 0);
        alu_wfi = 0; halt = 1; irq = 8'h02;
        step("wake_vs_ack", 0, 0, 0, 0, 0);
        halt = 0;
        step("req3", 1, 1, 32'h1044, 0, 0);
        dbg = 1;
        step("dbg", 0, 0, 0, 0, 0);
        alu_wfi = 1;
        step("dbg_wfi", 0, 0, 0, 0, 0);
        alu_wfi = 0; dbg = 0;
        step("dbg_off", 1, 1, 32'h1044, 0, 0);
        en = 8'hFD;
        step("masked", 0, 0, 0, 0, 0);
        en = 8'hFF; mtvec = 32'h1000; prio = 0;
        set_prio(1, 2); set_prio(4, 5); set_prio(3, 2); irq = 8'h02;
`ifdef EXCP_IRQ_NESTING_EN
        step("n1", 1, 1, 32'h1000, 0, 0);
        bus.cmt_vld_i = 1; exp_tk++;
        step("n1_take", 0, 0, 0, 0, 0);
        bus.cmt_vld_i = 0; irq = 8'h12;
        step("n2", 1, 4, 32'h1000, 0, 0);
        bus.cmt_vld_i = 1; exp_tk++;
        step("n2_take", 0, 0, 0, 0, 0);
        bus.cmt_vld_i = 0; irq = 8'h08;
        step("n3_block", 0, 0, 0, 0, 0);
        bus.mret_i = 1;
        step("n_pop1", 0, 0, 0, 0, 0);
        step("n_pop2", 1, 3, 32'h1000, 0, 0);
        bus.mret_i = 0;
        step("n3_req", 1, 3, 32'h1000, 0, 0);
`else
        step("b1", 1, 1, 32'h1000, 0, 0);
        bus.cmt_vld_i = 1; exp_tk++;
        step("b1_take", 0, 0, 0, 0, 0);
        bus.cmt_vld_i = 0; irq = 8'h12;
        step("no_preempt", 0, 0, 0, 0, 0);
        bus.mret_i = 1;
        step("b_mret", 1, 4, 32'h1000, 0, 0);
        bus.mret_i = 0;
`endif
        repeat (2) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
